zero_crossing_detector_mc: RTL and testbench
============================================

Name: zero_crossing_detector_mc

Overview:
- Multi-channel, parametrised zero-crossing / period meter for time-multiplexed ADC sample streams (AD9226 path, downstream of passband_filter).
- Per channel: qualifies threshold crossings with hysteresis, counts valid samples between qualified crossings, and averages over 2^k periods.
- Reports averaged period plus the free-running timestamp of the completing crossing; flags channels whose signal stops crossing (timeout).

Parameters:
- DATA_WIDTH, 16, sample width; unsigned offset-binary.
- NUM_CH, 2, number of interleaved channels (>=1).
- CH_WIDTH, 1, channel index width; must satisfy 2^CH_WIDTH >= NUM_CH.
- CNT_WIDTH, 32, period counter, timeout and timestamp width.
- AVG_LOG2_MAX, 4, maximum cfg_avg_log2.

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- in_data_valid  in  1  sample strobe
- in_data  in  DATA_WIDTH  sample
- in_channel  in  CH_WIDTH  channel of current sample; values >= NUM_CH are ignored
- in_counter_pos  in  CNT_WIDTH  free-running timestamp
- cfg_enable  in  1  0 = hold all channels idle and cleared
- cfg_threshold  in  DATA_WIDTH  crossing level (e.g. 2048)
- cfg_hysteresis  in  DATA_WIDTH  half-band around the threshold
- cfg_edge_mode  in  2  01 = rising, 10 = falling, 11 = both, 00 = none
- cfg_avg_log2  in  3  periods averaged = 2^k; values > AVG_LOG2_MAX are clamped
- cfg_timeout  in  CNT_WIDTH  max samples without a crossing; 0 = disabled
- out_data_valid  out  1  one-cycle result pulse
- out_channel  out  CH_WIDTH  channel of the result
- out_number_samples  out  CNT_WIDTH  averaged period in samples; 0 on timeout
- out_zcd_pos  out  CNT_WIDTH  in_counter_pos latched at the completing crossing
- out_timeout  out  1  one-cycle pulse, concurrent with out_data_valid

Behaviour:
- Reset clears all outputs to 0 and every channel state to UNKNOWN, with count, accumulator and period index at 0.
- Band limits: hi = min(thr+hyst, all-ones); lo = max(thr-hyst, 0). Computed at DATA_WIDTH+1 bits, then saturated.
- Level FSM per channel, updated only on that channel's valid sample:
  - UNKNOWN -> HIGH if sample >= hi; UNKNOWN -> LOW if sample <= lo; otherwise stay. No crossing is reported from UNKNOWN.
  - LOW -> HIGH when sample >= hi: rising crossing.
  - HIGH -> LOW when sample <= lo: falling crossing.
  - Samples strictly inside (lo, hi) cause no transition.
- A crossing is qualified if its direction is enabled in cfg_edge_mode.
- Measurement FSM per channel, states WAIT_FIRST and MEASURE:
  - WAIT_FIRST: on a qualified crossing, count <= 0, acc <= 0, idx <= 0, go to MEASURE. No output.
  - MEASURE, non-crossing sample: count <= count+1, saturating at all-ones.
  - MEASURE, qualified crossing: m = count+1 (saturated); acc += m; count <= 0; idx += 1; latch in_counter_pos.
  - When idx reaches 2^k: emit acc >> k, then clear acc and idx and stay in MEASURE.
- Accumulator width is CNT_WIDTH+AVG_LOG2_MAX.
- Timeout: in MEASURE, when cfg_timeout != 0 and the post-increment count == cfg_timeout:
  - emit out_timeout = 1, out_number_samples = 0, out_zcd_pos = in_counter_pos;
  - channel returns to WAIT_FIRST; level state is kept.
- Crossing and timeout on the same sample: the crossing wins.
- Latency: outputs register 1 cycle after the in_data_valid cycle that caused them. At most one result per cycle, because input is one channel per cycle.
- When out_data_valid = 0, the data outputs hold their last values.
- cfg_enable = 0: every channel is forced to UNKNOWN/WAIT_FIRST in the next cycle and no outputs are produced. Re-enable restarts cleanly.
- Changing cfg_avg_log2 or thresholds mid-run takes effect on the next sample. Accumulated state is not flushed, so the first average after a change is undefined but must not hang.
- rst asserted mid-measurement aborts it with no output.

Test Plan:
- Triangle 0..5000..0 (step 1, valid every 6 clk), ch0, thr 2048, hyst 16, rising, k=0 -> after the first rising crossing, a pulse every 10000 samples with out_number_samples = 10000; out_zcd_pos equals in_counter_pos at each crossing sample.
- Same stimulus with edge mode 11 -> results alternate; each equals the half-period distance of the triangle, and consecutive pairs sum to 10000.
- Square wave alternating 100/104-sample periods, k=2 -> out_number_samples = 102 every 4 periods. Noise of ±10 around 2048 with hyst 16 -> no crossings.
- Interleaved ch0 (period 200) and ch1 (period 50) on alternate valids -> out_channel tags each result correctly with 200 and 50; no cross-talk.
- Input stuck at 3000 after one crossing, cfg_timeout = 1000 -> out_timeout with out_number_samples = 0 on the 1000th sample after the crossing. The next two crossings give one normal result.
- rst pulse, and separately cfg_enable low for 3 cycles, mid-period -> no output. Thereafter the first crossing only arms; the next full period reports the correct value.

Source files
------------

// File: rtl/zero_crossing_detector_mc.sv
// zero_crossing_detector_mc
// Multi-channel zero-crossing / period meter for a time-multiplexed sample
// stream. Each channel qualifies threshold crossings with hysteresis, counts
// valid samples between qualified crossings and averages 2^k periods.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_data_valid       sample strobe
//   in_data             sample (unsigned offset-binary)
//   in_channel          channel of the sample (>= NUM_CH ignored)
//   in_counter_pos      free-running timestamp
//   cfg_enable          0 holds every channel idle and cleared
//   cfg_threshold       crossing level
//   cfg_hysteresis      half-band around the threshold
//   cfg_edge_mode       bit0 rising, bit1 falling
//   cfg_avg_log2        log2 of periods averaged (clamped to AVG_LOG2_MAX)
//   cfg_timeout         max samples without a crossing, 0 disables
//   out_data_valid      one-cycle result pulse
//   out_channel         channel of the result
//   out_number_samples  averaged period in samples, 0 on timeout
//   out_zcd_pos         timestamp of the completing crossing
//   out_timeout         one-cycle timeout pulse (with out_data_valid)
//
// Level FSM
//   state        | meaning
//   LVL_UNKNOWN  | no band decision yet, crossings not reported
//   LVL_LOW      | last decision was at or below the low band edge
//   LVL_HIGH     | last decision was at or above the high band edge
// Measurement FSM
//   state          | meaning
//   MS_WAIT_FIRST  | waiting for a qualified crossing to arm
//   MS_MEASURE     | counting samples between qualified crossings

module zero_crossing_detector_mc #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CH       = 2,
  parameter int CH_WIDTH     = 1,
  parameter int CNT_WIDTH    = 32,
  parameter int AVG_LOG2_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_data_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CH_WIDTH-1:0]   in_channel,
  input  logic [CNT_WIDTH-1:0]  in_counter_pos,
  input  logic                  cfg_enable,
  input  logic [DATA_WIDTH-1:0] cfg_threshold,
  input  logic [DATA_WIDTH-1:0] cfg_hysteresis,
  input  logic [1:0]            cfg_edge_mode,
  input  logic [2:0]            cfg_avg_log2,
  input  logic [CNT_WIDTH-1:0]  cfg_timeout,
  output logic                  out_data_valid,
  output logic [CH_WIDTH-1:0]   out_channel,
  output logic [CNT_WIDTH-1:0]  out_number_samples,
  output logic [CNT_WIDTH-1:0]  out_zcd_pos,
  output logic                  out_timeout
);

  localparam int ACC_W = CNT_WIDTH + AVG_LOG2_MAX;
  localparam int IDX_W = AVG_LOG2_MAX + 1;
  localparam int CH_W1 = CH_WIDTH + 1;
  localparam logic [2:0]       K_MAX  = 3'(AVG_LOG2_MAX);
  localparam logic [CH_W1-1:0] CH_LIM = CH_W1'(NUM_CH);

  typedef enum logic [1:0] {LVL_UNKNOWN, LVL_LOW, LVL_HIGH} lvl_e;
  typedef enum logic {MS_WAIT_FIRST, MS_MEASURE} meas_e;

  lvl_e                 lvl_q  [NUM_CH];
  meas_e                meas_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_q  [NUM_CH];
  logic [ACC_W-1:0]     acc_q  [NUM_CH];
  logic [IDX_W-1:0]     idx_q  [NUM_CH];

  // Band edges are formed one bit wider so overflow/underflow can saturate.
  logic [DATA_WIDTH:0]   hi_ext, lo_ext;
  logic [DATA_WIDTH-1:0] band_hi, band_lo;
  logic [2:0]            k_eff;
  logic                  ch_ok, fire;

  assign hi_ext  = {1'b0, cfg_threshold} + {1'b0, cfg_hysteresis};
  assign lo_ext  = {1'b0, cfg_threshold} - {1'b0, cfg_hysteresis};
  assign band_hi = hi_ext[DATA_WIDTH] ? '1 : hi_ext[DATA_WIDTH-1:0];
  assign band_lo = lo_ext[DATA_WIDTH] ? '0 : lo_ext[DATA_WIDTH-1:0];
  assign k_eff   = (cfg_avg_log2 > K_MAX) ? K_MAX : cfg_avg_log2;
  assign ch_ok   = ({1'b0, in_channel} < CH_LIM);
  assign fire    = in_data_valid & ch_ok;

  lvl_e                 lvl_cur, lvl_nxt;
  meas_e                meas_cur, meas_nxt;
  logic [CNT_WIDTH-1:0] cnt_cur, cnt_nxt, cnt_inc, emit_num;
  logic [ACC_W-1:0]     acc_cur, acc_nxt, acc_sum;
  logic [IDX_W-1:0]     idx_cur, idx_nxt, idx_inc;
  logic                 at_hi, at_lo, rise, fall, qual, emit, emit_tmo;

  always_comb begin
    lvl_cur  = lvl_q[in_channel];
    meas_cur = meas_q[in_channel];
    cnt_cur  = cnt_q[in_channel];
    acc_cur  = acc_q[in_channel];
    idx_cur  = idx_q[in_channel];
    lvl_nxt  = lvl_cur;
    meas_nxt = meas_cur;
    cnt_nxt  = cnt_cur;
    acc_nxt  = acc_cur;
    idx_nxt  = idx_cur;
    emit     = 1'b0;
    emit_tmo = 1'b0;
    emit_num = '0;
    rise     = 1'b0;
    fall     = 1'b0;
    at_hi    = (in_data >= band_hi);
    at_lo    = (in_data <= band_lo);

    case (lvl_cur)
      LVL_UNKNOWN: begin
        if (at_hi)      lvl_nxt = LVL_HIGH;
        else if (at_lo) lvl_nxt = LVL_LOW;
      end
      LVL_LOW: begin
        if (at_hi) begin
          lvl_nxt = LVL_HIGH;
          rise    = 1'b1;
        end
      end
      LVL_HIGH: begin
        if (at_lo) begin
          lvl_nxt = LVL_LOW;
          fall    = 1'b1;
        end
      end
      default: lvl_nxt = LVL_UNKNOWN;
    endcase

    qual    = (rise & cfg_edge_mode[0]) | (fall & cfg_edge_mode[1]);
    cnt_inc = (&cnt_cur) ? cnt_cur : cnt_cur + 1'b1;
    acc_sum = acc_cur + ACC_W'(cnt_inc);
    idx_inc = idx_cur + 1'b1;

    case (meas_cur)
      MS_WAIT_FIRST: begin
        if (qual) begin
          meas_nxt = MS_MEASURE;
          cnt_nxt  = '0;
          acc_nxt  = '0;
          idx_nxt  = '0;
        end
      end
      MS_MEASURE: begin
        if (qual) begin
          cnt_nxt = '0;
          // ">=" so a reduced cfg_avg_log2 still flushes a partly filled average.
          if (idx_inc >= (IDX_W'(1) << k_eff)) begin
            emit     = 1'b1;
            emit_num = CNT_WIDTH'(acc_sum >> k_eff);
            acc_nxt  = '0;
            idx_nxt  = '0;
          end else begin
            acc_nxt = acc_sum;
            idx_nxt = idx_inc;
          end
        end else if ((cfg_timeout != '0) && (cnt_inc == cfg_timeout)) begin
          emit     = 1'b1;
          emit_tmo = 1'b1;
          meas_nxt = MS_WAIT_FIRST;
          cnt_nxt  = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: meas_nxt = MS_WAIT_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        lvl_q[i]  <= LVL_UNKNOWN;
        meas_q[i] <= MS_WAIT_FIRST;
        cnt_q[i]  <= '0;
        acc_q[i]  <= '0;
        idx_q[i]  <= '0;
      end
      out_data_valid     <= 1'b0;
      out_channel        <= '0;
      out_number_samples <= '0;
      out_zcd_pos        <= '0;
      out_timeout        <= 1'b0;
    end else begin
      out_data_valid <= 1'b0;
      out_timeout    <= 1'b0;
      if (!cfg_enable) begin
        for (int i = 0; i < NUM_CH; i++) begin
          lvl_q[i]  <= LVL_UNKNOWN;
          meas_q[i] <= MS_WAIT_FIRST;
          cnt_q[i]  <= '0;
          acc_q[i]  <= '0;
          idx_q[i]  <= '0;
        end
      end else if (fire) begin
        lvl_q[in_channel]  <= lvl_nxt;
        meas_q[in_channel] <= meas_nxt;
        cnt_q[in_channel]  <= cnt_nxt;
        acc_q[in_channel]  <= acc_nxt;
        idx_q[in_channel]  <= idx_nxt;
        if (emit) begin
          out_data_valid     <= 1'b1;
          out_timeout        <= emit_tmo;
          out_channel        <= in_channel;
          out_number_samples <= emit_num;
          out_zcd_pos        <= in_counter_pos;
        end
      end
    end
  end

endmodule

// File: tb/tb_zero_crossing_detector_mc.sv
// Self-checking bench for zero_crossing_detector_mc. A behavioural model
// (band decisions, samples-since-crossing counter and a queue of measured
// periods per channel) predicts every output cycle by cycle; directed
// segments additionally check hand-derived period values.

module tb_zero_crossing_detector_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_data_valid;
  logic [15:0] in_data;
  logic [0:0]  in_channel;
  logic [31:0] in_counter_pos;
  logic        cfg_enable;
  logic [15:0] cfg_threshold;
  logic [15:0] cfg_hysteresis;
  logic [1:0]  cfg_edge_mode;
  logic [2:0]  cfg_avg_log2;
  logic [31:0] cfg_timeout;
  logic        out_data_valid;
  logic [0:0]  out_channel;
  logic [31:0] out_number_samples;
  logic [31:0] out_zcd_pos;
  logic        out_timeout;

  zero_crossing_detector_mc dut (
    .clk(clk), .rst(rst),
    .in_data_valid(in_data_valid), .in_data(in_data), .in_channel(in_channel),
    .in_counter_pos(in_counter_pos), .cfg_enable(cfg_enable),
    .cfg_threshold(cfg_threshold), .cfg_hysteresis(cfg_hysteresis),
    .cfg_edge_mode(cfg_edge_mode), .cfg_avg_log2(cfg_avg_log2),
    .cfg_timeout(cfg_timeout), .out_data_valid(out_data_valid),
    .out_channel(out_channel), .out_number_samples(out_number_samples),
    .out_zcd_pos(out_zcd_pos), .out_timeout(out_timeout)
  );

  always #5 clk = ~clk;

  int     n_chk = 0, n_pass = 0, n_fail = 0;
  longint ts = 0;

  // model state: level 0 unknown / 1 low / 2 high
  int     m_lvl   [2];
  bit     m_arm   [2];
  longint m_since [2];
  longint m_per   [2][$];

  bit     e_valid, e_tmo;
  longint e_ch, e_num, e_pos;

  int     n_ev = 0, n_tmo = 0;
  longint last_obs = 0, prev_obs = 0;
  longint last_ch [2];
  int     rw [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      m_lvl[c] = 0;
      m_arm[c] = 0;
      m_since[c] = 0;
      m_per[c].delete();
    end
  endtask

  task automatic step(input bit v, input int ch, input int d);
    int hi, lo, k;
    bit rise, fall, qual;
    longint sum;
    in_data_valid  = v;
    in_channel     = 1'(ch);
    in_data        = 16'(d);
    in_counter_pos = 32'(ts);
    if (rst) begin
      model_clear();
      e_valid = 0; e_tmo = 0; e_ch = 0; e_num = 0; e_pos = 0;
    end else if (!cfg_enable) begin
      model_clear();
      e_valid = 0; e_tmo = 0;
    end else begin
      e_valid = 0; e_tmo = 0;
      if (v) begin
        hi = int'(cfg_threshold) + int'(cfg_hysteresis);
        if (hi > 65535) hi = 65535;
        lo = int'(cfg_threshold) - int'(cfg_hysteresis);
        if (lo < 0) lo = 0;
        rise = (m_lvl[ch] == 1) && (d >= hi);
        fall = (m_lvl[ch] == 2) && (d <= lo);
        if (m_lvl[ch] == 0) m_lvl[ch] = (d >= hi) ? 2 : ((d <= lo) ? 1 : 0);
        else if (rise) m_lvl[ch] = 2;
        else if (fall) m_lvl[ch] = 1;
        qual = (rise && cfg_edge_mode[0]) || (fall && cfg_edge_mode[1]);
        k = (cfg_avg_log2 > 4) ? 4 : int'(cfg_avg_log2);
        if (!m_arm[ch]) begin
          if (qual) begin
            m_arm[ch] = 1;
            m_since[ch] = 0;
            m_per[ch].delete();
          end
        end else if (qual) begin
          m_per[ch].push_back(m_since[ch] + 1);
          m_since[ch] = 0;
          if (m_per[ch].size() >= (1 << k)) begin
            sum = 0;
            foreach (m_per[ch][i]) sum += m_per[ch][i];
            e_valid = 1; e_ch = ch; e_num = sum >> k; e_pos = ts;
            m_per[ch].delete();
          end
        end else begin
          m_since[ch]++;
          if (cfg_timeout != 0 && m_since[ch] == longint'(cfg_timeout)) begin
            e_valid = 1; e_tmo = 1; e_ch = ch; e_num = 0; e_pos = ts;
            m_arm[ch] = 0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    chk("valid", out_data_valid, e_valid);
    chk("timeout", out_timeout, e_tmo);
    chk("channel", out_channel, e_ch);
    chk("number", out_number_samples, e_num);
    chk("zcd_pos", out_zcd_pos, e_pos);
    if (out_data_valid === 1'b1) begin
      n_ev++;
      prev_obs = last_obs;
      last_obs = out_number_samples;
      last_ch[out_channel] = out_number_samples;
      if (out_timeout === 1'b1) n_tmo++;
    end
    ts++;
  endtask

  task automatic level(input int ch, input int val, input int n);
    for (int i = 0; i < n; i++) step(1, ch, val);
  endtask

  task automatic triangle(input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < 200; i++) begin step(1, 0, 1948 + i); step(0, 0, 0); end
      for (int i = 0; i < 200; i++) begin step(1, 0, 2148 - i); step(0, 0, 0); end
    end
  endtask

  task automatic flush();
    cfg_enable = 0;
    step(0, 0, 0);
    step(0, 0, 0);
    cfg_enable = 1;
  endtask

  int ev0, tmo0;

  initial begin
    rst = 1; cfg_enable = 1;
    cfg_threshold = 2000; cfg_hysteresis = 16; cfg_edge_mode = 2'b01;
    cfg_avg_log2 = 0; cfg_timeout = 0;
    last_ch[0] = 0; last_ch[1] = 0;
    model_clear();
    step(0, 0, 0); step(1, 0, 3000); step(0, 0, 0);
    rst = 0;

    // triangle, rising only: one result per 400-sample period
    ev0 = n_ev;
    triangle(3);
    chk("tri_rise_period", last_obs, 400);
    chk("tri_rise_count", n_ev - ev0, 2);

    // both edges: 296 / 104 alternate with thr 2000, hyst 16
    flush();
    cfg_edge_mode = 2'b11;
    ev0 = n_ev;
    triangle(3);
    chk("tri_both_last", last_obs, 296);
    chk("tri_both_pair", last_obs + prev_obs, 400);
    chk("tri_both_count", n_ev - ev0, 5);

    // square, periods alternate 100/104, average of 4 is 102
    flush();
    cfg_threshold = 2048; cfg_edge_mode = 2'b01; cfg_avg_log2 = 2;
    ev0 = n_ev;
    for (int p = 0; p < 12; p++) begin
      level(0, 1000, 50);
      level(0, 3000, (p % 2) ? 54 : 50);
    end
    chk("square_avg", last_obs, 102);
    chk("square_count", n_ev - ev0, 2);

    // noise inside the hysteresis band never crosses
    flush();
    cfg_edge_mode = 2'b11; cfg_avg_log2 = 0;
    ev0 = n_ev;
    for (int i = 0; i < 300; i++) step(1, 0, 2038 + int'($urandom_range(0, 20)));
    chk("noise_count", n_ev - ev0, 0);

    // interleaved channels, periods 200 and 50
    flush();
    cfg_edge_mode = 2'b01;
    ev0 = n_ev;
    for (int i = 0; i < 1000; i++) begin
      step(1, 0, ((i / 100) % 2) ? 3000 : 1000);
      step(1, 1, ((i / 25) % 2) ? 3000 : 1000);
    end
    chk("ilv_ch0", last_ch[0], 200);
    chk("ilv_ch1", last_ch[1], 50);
    chk("ilv_count", n_ev - ev0, 23);

    // timeout on the 100th sample after the arming crossing
    flush();
    cfg_timeout = 100;
    ev0 = n_ev; tmo0 = n_tmo;
    level(0, 1000, 20);
    level(0, 3000, 150);
    chk("tmo_count", n_tmo - tmo0, 1);
    chk("tmo_number", last_obs, 0);
    level(0, 1000, 30); level(0, 3000, 40);
    level(0, 1000, 30); level(0, 3000, 10);
    chk("tmo_recover", last_obs, 70);
    chk("tmo_results", n_ev - ev0, 2);
    cfg_timeout = 0;

    // reset mid-period aborts; the next full period measures correctly
    flush();
    level(0, 1000, 40); level(0, 3000, 40); level(0, 1000, 40); level(0, 3000, 20);
    rst = 1; step(1, 0, 3000); rst = 0;
    ev0 = n_ev;
    level(0, 3000, 20); level(0, 1000, 40); level(0, 3000, 40);
    chk("rst_arm_only", n_ev - ev0, 0);
    level(0, 1000, 40); level(0, 3000, 40);
    chk("rst_period", last_obs, 80);
    chk("rst_count", n_ev - ev0, 1);

    // enable low for 3 cycles mid-period
    level(0, 1000, 20);
    cfg_enable = 0;
    step(1, 0, 1000); step(1, 0, 3000); step(1, 0, 1000);
    cfg_enable = 1;
    ev0 = n_ev;
    level(0, 1000, 20); level(0, 3000, 40); level(0, 1000, 40);
    chk("en_arm_only", n_ev - ev0, 0);
    level(0, 3000, 40);
    chk("en_period", last_obs, 80);

    // band edges saturating at all-ones and at zero
    flush();
    cfg_threshold = 65530; cfg_hysteresis = 20;
    ev0 = n_ev;
    for (int p = 0; p < 3; p++) begin level(0, 65400, 10); level(0, 65535, 10); end
    chk("sat_hi", last_obs, 20);
    flush();
    cfg_threshold = 5;
    for (int p = 0; p < 3; p++) begin level(0, 0, 10); level(0, 100, 10); end
    chk("sat_lo", last_obs, 20);
    chk("sat_count", n_ev - ev0, 4);

    // randomized: random walks on both channels, random configurations
    for (int blk = 0; blk < 8; blk++) begin
      flush();
      cfg_threshold  = 16'(1948 + $urandom_range(0, 200));
      cfg_hysteresis = 16'($urandom_range(0, 40));
      cfg_edge_mode  = 2'($urandom_range(0, 3));
      cfg_avg_log2   = 3'($urandom_range(0, 7));
      cfg_timeout    = ($urandom_range(0, 1) != 0) ? 32'd60 : 32'd0;
      rw[0] = 2048; rw[1] = 2048;
      for (int i = 0; i < 500; i++) begin
        int ch;
        bit v;
        v  = ($urandom_range(0, 3) != 0);
        ch = int'($urandom_range(0, 1));
        if (v) begin
          rw[ch] += int'($urandom_range(0, 80)) - 40;
          if (rw[ch] < 1500) rw[ch] = 1500;
          if (rw[ch] > 2600) rw[ch] = 2600;
        end
        step(v, ch, rw[ch]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
